mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Initiator-side load/store controller that drives the word-only data memory on behalf of the core. It accepts byte, halfword and word requests. Sub-word stores are turned into read-modify-write sequences. Loads have the addressed lane extracted and sign- or zero-extended. Misaligned and out-of-range requests are rejected without touching memory.

Parameters:
MEM_WORDS, 16384, number of 32-bit words in the data memory; byte addresses at or above 4*MEM_WORDS are out of range.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous reset, active-low.
req_valid  input  1  core request present.
req_ready  output  1  unit can accept a request; high only in IDLE.
req_write  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-justified.
resp_valid  output  1  one-cycle pulse: request complete.
resp_err  output  1  valid with resp_valid; misaligned, illegal size or out of range.
resp_rdata  output  32  load result; 0 for stores and errors.
address  output  32  to memory; always word-aligned (req_addr with [1:0] cleared).
writeData  output  32  to memory; merged store word.
memRead  output  1  to memory.
memWrite  output  1  to memory; the memory writes on the posedge at which this is high.
readdata  input  32  from memory; combinational, valid in the same cycle as memRead.

Behaviour:
- Reset (rst=0 at posedge): state IDLE; resp_valid=0, resp_err=0, resp_rdata=0; captured address, data and size cleared. memRead and memWrite are forced to 0 in any cycle with rst=0, so no memory write is issued during reset.
- States: IDLE, READ, WRITE, RESP.
- Acceptance: a request is accepted at the posedge where req_valid & req_ready; call that cycle T. All request fields are captured at that edge.
- Error check at acceptance, with no memory access on error; the request is an error if any of these hold:
  - req_size==11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr >= 4*MEM_WORDS.
  On error: IDLE->RESP; resp_valid=1 with resp_err=1 in T+1.
- Word store: IDLE->WRITE; memWrite=1 with writeData=wdata in T+1; RESP in T+2.
- Sub-word store: IDLE->READ (memRead=1 in T+1, readdata captured) -> WRITE (T+2, writeData = captured word with the selected lane(s) replaced by wdata[7:0] or wdata[15:0]) -> RESP in T+3.
- Load: IDLE->READ (T+1, readdata captured) -> RESP in T+2. resp_rdata holds the extracted lane, extended per req_unsigned; words pass through unchanged.
- Lane ordering is little-endian: byte k = bits 8k+7:8k, where k = addr[1:0]. A halfword uses bytes addr[1]*2 and addr[1]*2+1.
- RESP lasts exactly one cycle, then IDLE; req_ready returns to 1 in the cycle after RESP.
- memRead is high only in READ, memWrite only in WRITE, and never both in the same cycle.
- address is held constant from READ through WRITE.
- Reset mid-operation: the sequence is abandoned and no response is produced. Memory is unchanged unless WRITE already completed before the reset cycle.
- resp_rdata and resp_err are valid only while resp_valid=1 and read 0 otherwise.
- req_valid while busy is ignored; the requester holds it until accepted.

Decomposition:
- Shared package mau_pkg holds:
  - the size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum (IDLE, READ, WRITE, RESP);
  - the function computing the error flag.
- One combinational sub-module, mau_lane_align, takes the word, addr[1:0], size, unsigned flag and store data. It outputs the extracted/extended load value and the merged store word. The FSM lives in mem_access_unit.

Test Plan:
- Memory preload word 0x10 = 0x8899AABB; word load at 0x10 accepted at T -> memRead=1, address 0x10 in T+1; resp_valid, rdata=0x8899AABB, err=0 in T+2.
- Loads at 0x13 signed byte -> 0xFFFFFF88; 0x13 unsigned byte -> 0x00000088; 0x12 signed half -> 0xFFFF8899; 0x10 unsigned half -> 0x0000AABB.
- Byte store 0x11, wdata 0x123456CC -> memRead in T+1, memWrite in T+2 with writeData 0x8899CCBB, resp in T+3; a following word load at 0x10 returns 0x8899CCBB.
- Half load 0x11, word store 0x0E, size 11, and word load 0x10000 -> each resp_valid in T+1 with err=1, rdata=0; memRead and memWrite never asserted.
- rst=0 during the WRITE cycle of a byte store to 0x10 -> memWrite=0 that cycle, word 0x10 still 0x8899AABB, no resp_valid, req_ready=1 in the first cycle after rst returns high.
- Back-to-back: word store 0x20=0xDEADBEEF immediately followed by byte load 0x23 -> second request accepted in the cycle after RESP; rdata=0xFFFFFFDE.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared types and helpers for the load/store access unit.
package mau_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_e;

    typedef struct packed {
        logic              write;
        size_e             size;
        logic              is_unsigned;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Illegal size, misalignment for the access width, or beyond the end of memory.
    function automatic logic req_err(input size_e size, input logic [ADDR_W-1:0] addr,
                                     input int unsigned mem_words);
        logic [ADDR_W+1:0] limit;
        logic              misaligned;
        limit = (ADDR_W+2)'(mem_words) << 2;
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr[0];
            SZ_WORD: misaligned = |addr[1:0];
            default: misaligned = 1'b1;
        endcase
        return misaligned || ({2'b00, addr} >= limit);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core request/response channel plus the word-wide data memory port.
interface mem_access_unit_if;
    import mau_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writeData;
    logic              memRead;
    logic              memWrite;
    logic [DATA_W-1:0] readdata;

    // The unit side.
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, readdata,
        output req_ready, resp_valid, resp_err, resp_rdata, address, writeData, memRead, memWrite
    );

    // The core plus memory side.
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, readdata,
        input  req_ready, resp_valid, resp_err, resp_rdata, address, writeData, memRead, memWrite
    );

endinterface

// File: rtl/mau_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for stores.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        offset,
    input  size_e             size,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_val,
    output logic [DATA_W-1:0] store_word
);

    logic [4:0]        shamt;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] mask;
    logic              sext;

    always_comb begin
        shamt      = (size == SZ_HALF) ? {offset[1], 4'b0000} : {offset, 3'b000};
        lane       = word >> shamt;
        mask       = '1;
        load_val   = lane;
        sext       = 1'b0;
        case (size)
            SZ_BYTE: begin
                sext     = ~is_unsigned & lane[7];
                load_val = {{24{sext}}, lane[7:0]};
                mask     = DATA_W'(32'h0000_00FF) << shamt;
            end
            SZ_HALF: begin
                sext     = ~is_unsigned & lane[15];
                load_val = {{16{sext}}, lane[15:0]};
                mask     = DATA_W'(32'h0000_FFFF) << shamt;
            end
            default: ;
        endcase
        // Store data is right-justified; shift it into the target lane(s).
        store_word = (word & ~mask) | ((wdata << shamt) & mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store controller: byte/half/word access to a word-only memory via RMW.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 16384
)
(
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);

    state_e            state_q, state_d;
    req_t              req_q;
    size_e             req_size;
    logic              accept;
    logic              req_bad;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] align_word;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] store_word;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    assign req_size   = size_e'(bus.req_size);
    assign accept     = bus.req_valid && (state_q == IDLE);
    assign req_bad    = req_err(req_size, bus.req_addr, MEM_WORDS);
    // Loads use the live memory word; the store merge uses the word captured in READ.
    assign align_word = (state_q == READ) ? bus.readdata : word_q;

    mau_lane_align u_lane_align (
        .word        (align_word),
        .offset      (req_q.addr[1:0]),
        .size        (req_q.size),
        .is_unsigned (req_q.is_unsigned),
        .wdata       (req_q.wdata),
        .load_val    (load_val),
        .store_word  (store_word)
    );

    // Next-state and response generation.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (bus.req_write && (req_size == SZ_WORD)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (req_q.write) begin
                    state_d = WRITE;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_val;
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            word_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            if (accept) begin
                req_q <= '{write:       bus.req_write,
                           size:        req_size,
                           is_unsigned: bus.req_unsigned,
                           addr:        bus.req_addr,
                           wdata:       bus.req_wdata};
            end
            if (state_q == READ) begin
                word_q <= bus.readdata;
            end
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.address    = {req_q.addr[ADDR_W-1:2], 2'b00};
    assign bus.writeData  = store_word;
    // Memory strobes are suppressed while reset is asserted.
    assign bus.memRead    = rst && (state_q == READ);
    assign bus.memWrite   = rst && (state_q == WRITE);

endmodule
